// File: rtl/vgade0_pkg.sv
// Shared definitions for the character-cell video pipeline.
package vgade0_pkg;

  localparam int CHARWIDTH = 8;
  localparam int RGB_W     = 3;
  localparam int CNT_W     = $clog2(CHARWIDTH);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHARWIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Colour of one glyph pixel: set bits use fg unless the blink dims them.
  function automatic logic [RGB_W-1:0] pick_rgb(input logic             bit_v,
                                                input logic             dim,
                                                input logic [RGB_W-1:0] f,
                                                input logic [RGB_W-1:0] b);
    return (bit_v && !dim) ? f : b;
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Frame counter that produces the character blink phase.
// Built into the serializer only when VGADE0_BLINK_EN is defined.
module blink_timer
#(
  parameter int BLINK_BIT = 4
)
(
  input  logic clk,
  input  logic reset_n,
  input  logic frame_start,
  output logic phase
);

  logic [7:0] frame_cnt_q;

  // Count frames; the counter wraps naturally from 255 to 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= 8'd0;
    end else if (frame_start) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign phase = frame_cnt_q[BLINK_BIT];

endmodule

// File: rtl/pixel_serializer.sv
// Glyph-row serializer: turns an 8-bit character-generator row plus
// fg/bg attributes into one registered RGB pixel per clock.
// Optional blink support is compiled in with `define VGADE0_BLINK_EN.
//
// Handshake: load is a one-cycle strobe with no back-pressure; row_pixels
// and the attributes are valid only in the cycle load is high. The source
// must present the next row in the cycle the last bit is on screen
// (counter==7); earlier sets overrun, later sets underrun.
module pixel_serializer
  import vgade0_pkg::*;
#(
  parameter int               BLINK_BIT = 4,
  parameter logic [RGB_W-1:0] BLANK_RGB = 3'b000
)
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [CHARWIDTH-1:0] row_pixels,
  input  logic [RGB_W-1:0]     fg,
  input  logic [RGB_W-1:0]     bg,
  input  logic                 blink,
  input  logic                 frame_start,
  input  logic                 blank,
  output logic [RGB_W-1:0]     pixel_rgb,
  output logic                 busy,
  output logic                 underrun,
  output logic                 overrun,
  output state_e               state_dbg
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHARWIDTH-1:0] shreg_q, shreg_d;
  logic [RGB_W-1:0]     fg_q, fg_d, bg_q, bg_d;
  logic                 blink_q, blink_d;
  logic [RGB_W-1:0]     pix_q, pix_d;
  logic                 underrun_q, underrun_d;
  logic                 overrun_q, overrun_d;
  logic                 dim_new;  // blink dims the row being loaded
  logic                 dim_cur;  // blink dims the row in flight

`ifdef VGADE0_BLINK_EN
  logic phase;

  blink_timer #(.BLINK_BIT(BLINK_BIT)) u_blink_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .phase       (phase)
  );

  assign dim_new = blink & phase;
  assign dim_cur = blink_q & phase;
`else
  // Blink is ignored in this build; these only keep the inputs referenced.
  localparam int unused_blink_bit = BLINK_BIT;
  logic unused_blink;
  assign unused_blink = ^{blink_q, frame_start};
  assign dim_new      = 1'b0;
  assign dim_cur      = 1'b0;
`endif

  // State, datapath and flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      fg_q       <= '0;
      bg_q       <= '0;
      blink_q    <= 1'b0;
      pix_q      <= BLANK_RGB;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      fg_q       <= fg_d;
      bg_q       <= bg_d;
      blink_q    <= blink_d;
      pix_q      <= pix_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
    end
  end

  // Next state: load always wins, otherwise shift or fall back to IDLE.
  // The pixel register is loaded with the colour of the bit that will be
  // current after this edge, which gives load-to-first-pixel latency of 1.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    fg_d       = fg_q;
    bg_d       = bg_q;
    blink_d    = blink_q;
    pix_d      = bg_q;
    underrun_d = underrun_q;
    overrun_d  = overrun_q;

    if (load) begin
      state_d = SHIFT;
      cnt_d   = '0;
      shreg_d = row_pixels;
      fg_d    = fg;
      bg_d    = bg;
      blink_d = blink;
      pix_d   = pick_rgb(row_pixels[CHARWIDTH-1], dim_new, fg, bg);
      if (state_q == SHIFT && cnt_q != LAST_BIT) begin
        overrun_d = 1'b1;
      end
    end else if (state_q == SHIFT) begin
      if (cnt_q == LAST_BIT) begin
        state_d = IDLE;
        pix_d   = bg_q;
        if (!blank) begin
          underrun_d = 1'b1;
        end
      end else begin
        shreg_d = {shreg_q[CHARWIDTH-2:0], 1'b0};
        cnt_d   = cnt_q + CNT_W'(1);
        pix_d   = pick_rgb(shreg_q[CHARWIDTH-2], dim_cur, fg_q, bg_q);
      end
    end

    // Blanking overrides the colour only; shifting carries on underneath.
    if (blank) begin
      pix_d = BLANK_RGB;
    end
  end

  assign pixel_rgb = pix_q;
  assign busy      = (state_q == SHIFT);
  assign underrun  = underrun_q;
  assign overrun   = overrun_q;
  assign state_dbg = state_q;

endmodule
